// File: rtl/swo_rx_pkg.sv
// Shared encodings and limits for the SWO UART receiver (swo_uart_rx, swo_rx_sync).
// Pure constants and types, no logic and no latency of its own.
package swo_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int MIN_DATA_BITS = 5;
  localparam int MIN_DIV       = 3;

  // I_stop_bits codes that select two stop bits; all other codes mean one.
  localparam logic [1:0] STOP_CFG_TWO   = 2'd2;
  localparam logic [1:0] STOP_CFG_THREE = 2'd3;

endpackage

// File: rtl/swo_rx_sync.sv
// SWO pin synchronizer + falling-edge detect; 2-cycle latency, no backpressure.
// SWO_RX_MAJORITY_EN adds a 3-tap window so smp_o is the 2-of-3 vote of the last three line values.
module swo_rx_sync (
  input  logic uart_clk,
  input  logic reset_i,
  input  logic swo_i,
  output logic smp_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = swo_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Reset to the idle line level so releasing reset never looks like a start edge.
  always_ff @(posedge uart_clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign fall_o = prev_q & ~sync2_q;

`ifdef SWO_RX_MAJORITY_EN
  logic prev2_q, prev2_d;

  assign prev2_d = prev_q;

  always_ff @(posedge uart_clk or posedge reset_i) begin
    if (reset_i) prev2_q <= 1'b1;
    else         prev2_q <= prev2_d;
  end

  assign smp_o = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
`else
  assign smp_o = sync2_q;
`endif

endmodule

// File: rtl/swo_uart_rx.sv
// SWO UART-framed receiver: strobes O_data_valid/O_framing_error 1 cycle after the last stop sample (+1 with
// SWO_RX_MAJORITY_EN); no backpressure, every strobe is a single cycle and the consumer must take it.
module swo_uart_rx
  import swo_rx_pkg::*;
#(
  parameter int pDATA_MAX  = 8,
  parameter int pDIV_WIDTH = 8
) (
  input  logic                  uart_clk,
  input  logic                  reset_i,
  input  logic                  I_swo_enable,
  input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
  input  logic [1:0]            I_stop_bits,
  input  logic [3:0]            I_data_bits,
  input  logic                  I_swo,
  output logic [pDATA_MAX-1:0]  O_data,
  output logic                  O_data_valid,
  output logic                  O_framing_error,
  output logic                  O_busy
);

  localparam int NW = $clog2(pDATA_MAX + 1);

  logic smp, fall, smp_evt, cnt_zero, err_n;
  logic [pDIV_WIDTH-1:0] pm1_cfg, h_m1_cfg;
  logic [NW-1:0]         nb_cfg;
  logic                  two_stop_cfg;

  rx_state_e             state_q, state_d;
  logic [pDIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [pDIV_WIDTH-1:0] pm1_q, pm1_d;
  logic [NW-1:0]         nb_q, nb_d;
  logic [NW-1:0]         idx_q, idx_d;
  logic                  two_stop_q, two_stop_d;
  logic                  sidx_q, sidx_d;
  logic                  err_q, err_d;
  logic [pDATA_MAX-1:0]  sh_q, sh_d;
  logic [pDATA_MAX-1:0]  data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  ferr_q, ferr_d;

  swo_rx_sync u_sync (
    .uart_clk (uart_clk),
    .reset_i  (reset_i),
    .swo_i    (I_swo),
    .smp_o    (smp),
    .fall_o   (fall)
  );

  assign cnt_zero = (cnt_q == '0);

`ifdef SWO_RX_MAJORITY_EN
  // The vote needs the line one cycle past cnt==0, so the sample is acted on a cycle later.
  logic evt_q, evt_d;
  assign evt_d   = (state_q != ST_IDLE) && cnt_zero && I_swo_enable;
  assign smp_evt = evt_q;

  always_ff @(posedge uart_clk or posedge reset_i) begin
    if (reset_i) evt_q <= 1'b0;
    else         evt_q <= evt_d;
  end
`else
  assign smp_evt = (state_q != ST_IDLE) && cnt_zero;
`endif

  // Frame configuration as it would be latched at a start edge.
  always_comb begin
    pm1_cfg  = (I_bitrate_div < pDIV_WIDTH'(MIN_DIV)) ? pDIV_WIDTH'(MIN_DIV) : I_bitrate_div;
    h_m1_cfg = (pm1_cfg >> 1) + pDIV_WIDTH'(pm1_cfg[0]) - pDIV_WIDTH'(1);
    if (int'(I_data_bits) < MIN_DATA_BITS)  nb_cfg = NW'(MIN_DATA_BITS);
    else if (int'(I_data_bits) > pDATA_MAX) nb_cfg = NW'(pDATA_MAX);
    else                                    nb_cfg = NW'(I_data_bits);
    two_stop_cfg = (I_stop_bits == STOP_CFG_TWO) || (I_stop_bits == STOP_CFG_THREE);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pm1_d      = pm1_q;
    nb_d       = nb_q;
    idx_d      = idx_q;
    two_stop_d = two_stop_q;
    sidx_d     = sidx_q;
    err_d      = err_q;
    sh_d       = sh_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    ferr_d     = 1'b0;
    err_n      = err_q | ~smp;

    if (state_q == ST_IDLE) begin
      if (fall && I_swo_enable) begin
        pm1_d      = pm1_cfg;
        nb_d       = nb_cfg;
        two_stop_d = two_stop_cfg;
        cnt_d      = h_m1_cfg;
        state_d    = ST_START;
      end
    end else begin
      cnt_d = cnt_zero ? pm1_q : cnt_q - pDIV_WIDTH'(1);
    end

    if (smp_evt) begin
      case (state_q)
        ST_START: begin
          idx_d   = '0;
          state_d = smp ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          sh_d = {smp, sh_q[pDATA_MAX-1:1]};
          if (idx_q == nb_q - NW'(1)) begin
            sidx_d  = 1'b0;
            err_d   = 1'b0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + NW'(1);
          end
        end
        ST_STOP: begin
          err_d = err_n;
          if (sidx_q == two_stop_q) begin
            state_d = ST_IDLE;
            if (err_n) begin
              ferr_d = 1'b1;
            end else begin
              vld_d  = 1'b1;
              data_d = sh_q >> (pDATA_MAX - int'(nb_q));
            end
          end else begin
            sidx_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Disabling abandons any partial frame without reporting it.
    if (!I_swo_enable) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge uart_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pm1_q      <= '0;
      nb_q       <= '0;
      idx_q      <= '0;
      two_stop_q <= 1'b0;
      sidx_q     <= 1'b0;
      err_q      <= 1'b0;
      sh_q       <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pm1_q      <= pm1_d;
      nb_q       <= nb_d;
      idx_q      <= idx_d;
      two_stop_q <= two_stop_d;
      sidx_q     <= sidx_d;
      err_q      <= err_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      ferr_q     <= ferr_d;
    end
  end

  assign O_data          = data_q;
  assign O_data_valid    = vld_q;
  assign O_framing_error = ferr_q;
  assign O_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_swo_uart_rx.sv
// Bench for swo_uart_rx: frames are driven at pin level and every strobe (cycle, kind, data) is compared
// against a frame-level model built from the bit-timing and framing rules.
module tb_swo_uart_rx;

`ifdef SWO_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       uart_clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       I_swo_enable = 1'b1;
  logic [7:0] I_bitrate_div = 8'd7;
  logic [1:0] I_stop_bits = 2'd1;
  logic [3:0] I_data_bits = 4'd8;
  logic       I_swo = 1'b1;
  logic [7:0] O_data;
  logic       O_data_valid, O_framing_error, O_busy;

  swo_uart_rx dut (
    .uart_clk        (uart_clk),
    .reset_i         (reset_i),
    .I_swo_enable    (I_swo_enable),
    .I_bitrate_div   (I_bitrate_div),
    .I_stop_bits     (I_stop_bits),
    .I_data_bits     (I_data_bits),
    .I_swo           (I_swo),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .O_framing_error (O_framing_error),
    .O_busy          (O_busy)
  );

  always #5 uart_clk = ~uart_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_total = 0;
  int ev_cyc[$], ev_kind[$], ev_dat[$];
  int ex_cyc[$], ex_kind[$], ex_dat[$];
  int ev_rd = 0;
  logic [7:0] last_data = 8'h00;

  always @(posedge uart_clk) cyc <= cyc + 1;

  // kind: 1 = data valid, 2 = framing error, 3 = both at once
  always @(negedge uart_clk) begin
    if (!reset_i) begin
      if (O_busy) busy_total <= busy_total + 1;
      if (O_data_valid || O_framing_error) begin
        ev_cyc.push_back(cyc);
        ev_kind.push_back({30'd0, O_framing_error, O_data_valid});
        ev_dat.push_back(int'(O_data));
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int p_of(input int div);
    return ((div < 3) ? 3 : div) + 1;
  endfunction

  function automatic int n_of(input int db);
    return (db < 5) ? 5 : ((db > 8) ? 8 : db);
  endfunction

  function automatic int s_of(input int sc);
    return (sc == 2 || sc == 3) ? 2 : 1;
  endfunction

  task automatic hold(input logic v, input int n);
    I_swo = v;
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  // Drives one frame and queues the strobe the receiver owes for it.
  task automatic send_frame(input logic [7:0] b, input int div, input int db, input int sc,
                            input logic [1:0] stv, input int div_mid);
    int p, n, s;
    bit err;
    I_bitrate_div = 8'(div);
    I_data_bits   = 4'(db);
    I_stop_bits   = 2'(sc);
    p   = p_of(div);
    n   = n_of(db);
    s   = s_of(sc);
    err = (stv[0] == 1'b0) || (s == 2 && stv[1] == 1'b0);
    ex_cyc.push_back(cyc + 3 + p / 2 + (n + s) * p + MAJ);
    ex_kind.push_back(err ? 2 : 1);
    if (!err) last_data = b & 8'((1 << n) - 1);
    ex_dat.push_back(int'(last_data));
    hold(1'b0, p);
    for (int i = 0; i < n; i++) begin
      hold(b[i], p);
      if (i == 2 && div_mid >= 0) I_bitrate_div = 8'(div_mid);
    end
    for (int i = 0; i < s; i++) hold(stv[i], p);
  endtask

  task automatic check_events(input string t);
    int n_new;
    n_new = ev_cyc.size() - ev_rd;
    chk_eq({t, "_ev_count"}, n_new, ex_cyc.size());
    for (int i = 0; i < ex_cyc.size() && i < n_new; i++) begin
      chk_eq({t, "_ev_cycle"}, ev_cyc[ev_rd + i], ex_cyc[i]);
      chk_eq({t, "_ev_kind"}, ev_kind[ev_rd + i], ex_kind[i]);
      chk_eq({t, "_ev_data"}, ev_dat[ev_rd + i], ex_dat[i]);
    end
    ev_rd = ev_cyc.size();
    ex_cyc.delete();
    ex_kind.delete();
    ex_dat.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int b0, div, db, sc, s, gap;
    logic [7:0] b;
    logic [1:0] stv;

    repeat (3) @(posedge uart_clk);
    #1;
    chk_eq("rst_data", O_data, 0);
    chk_eq("rst_valid", O_data_valid, 0);
    chk_eq("rst_ferr", O_framing_error, 0);
    chk_eq("rst_busy", O_busy, 0);
    reset_i = 1'b0;
    hold(1'b1, 5);

    // 8N1, P=8
    b0 = busy_total;
    send_frame(8'hA5, 7, 8, 1, 2'b11, -1);
    hold(1'b1, 10);
    chk_eq("t1_busy_cycles", busy_total - b0, 8 / 2 + 9 * 8 + MAJ);
    check_events("t1");

    // 5N2 back-to-back, P=16
    send_frame(8'h15, 15, 5, 2, 2'b11, -1);
    send_frame(8'h0A, 15, 5, 2, 2'b11, -1);
    hold(1'b1, 20);
    check_events("t2");
    chk_eq("t2_data", O_data, 8'h0A);

    // stop bit low, then line held low (break)
    send_frame(8'h3C, 7, 8, 1, 2'b10, -1);
    hold(1'b0, 3 * 8);
    hold(1'b1, 20);
    check_events("t3");
    chk_eq("t3_data_held", O_data, last_data);

    // 2-cycle glitch
    I_bitrate_div = 8'd7;
    b0 = busy_total;
    hold(1'b0, 2);
    hold(1'b1, 8 + 3);
    chk_eq("t4_busy_idle", O_busy, 0);
    chk_eq("t4_busy_cycles", busy_total - b0, 8 / 2 + MAJ);
    check_events("t4");

    // divider changed after third data bit; frame stays at P=8
    send_frame(8'hC3, 7, 8, 1, 2'b11, 15);
    hold(1'b1, 20);
    check_events("t5a");

    // enable dropped mid-frame
    I_bitrate_div = 8'd7;
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    chk_eq("t5b_busy_mid", O_busy, 1);
    I_swo_enable = 1'b0;
    @(posedge uart_clk);
    @(negedge uart_clk);
    chk_eq("t5b_busy_off", O_busy, 0);
    @(posedge uart_clk);
    #1;
    hold(1'b0, 16);
    hold(1'b1, 20);
    I_swo_enable = 1'b1;
    hold(1'b1, 10);
    check_events("t5b");

    // asynchronous reset during DATA
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    #3;
    reset_i = 1'b1;
    #1;
    chk_eq("t6_rst_data", O_data, 0);
    chk_eq("t6_rst_busy", O_busy, 0);
    chk_eq("t6_rst_valid", O_data_valid, 0);
    @(posedge uart_clk);
    #1;
    I_swo = 1'b1;
    repeat (2) @(posedge uart_clk);
    #1;
    reset_i = 1'b0;
    last_data = 8'h00;
    hold(1'b1, 10);
    send_frame(8'h5A, 7, 8, 1, 2'b11, -1);
    hold(1'b1, 20);
    check_events("t6");

    // randomized frames, mixed configs, some back-to-back, some with bad stop bits
    for (int f = 0; f < 40; f++) begin
      div = int'($urandom_range(0, 12));
      db  = int'($urandom_range(0, 15));
      sc  = int'($urandom_range(0, 3));
      b   = 8'($urandom);
      s   = s_of(sc);
      stv = 2'b11;
      if ($urandom_range(0, 5) == 0) stv[$urandom_range(0, s - 1)] = 1'b0;
      send_frame(b, div, db, sc, stv, -1);
      gap = int'($urandom_range(0, 3));
      if (stv != 2'b11) gap += p_of(div);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 30);
    check_events("rnd");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
